// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types and constants used by the fetch stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rv32i_pkg;

   localparam int XLEN   = 32;
   localparam int INST_W = 32;

   // Fetch advances one 32-bit word at a time.
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   // One prefetched instruction together with the address it came from.
   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, inst} entries with synchronous flush; DEPTH is a power of two.
// Latency: a pushed entry is visible at head in the cycle after the push.
// Backpressure: none internally; the producer's credit logic must never push when full.
module fetch_queue
   import rv32i_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  fetch_entry_t           wr_entry,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // Storage, pointers and occupancy; flush empties the queue ahead of any push/pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_entry;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one-outstanding imem reads, buffers words for execute.
// Latency: a word acked in cycle N is presented on inst_valid in cycle N+1; 1 inst/cycle on zero-wait memory.
// Backpressure: inst_ready low fills the queue, then imem_req is withheld until a slot is credited back.
// Optional FETCH_MISALIGN_CHK_EN: a misaligned redirect raises misalign_err and halts fetch.
module fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        misalign_err
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [31:0]      fetch_pc;
   logic [31:0]      fetch_pc_next;
   logic [31:0]      redirect_tgt;
   logic             drop_flag;
   logic             drop_next;
   logic             halted;
   logic             halted_next;
   logic             ack_fire;
   logic             out_hold;
   logic             push;
   logic             pop;
   logic             req_next;
   logic [CNT_W-1:0] q_count;
   logic [CNT_W-1:0] count_next;
   logic             q_full;
   logic             q_empty;
   fetch_entry_t     q_head;
   fetch_entry_t     q_wr;

   // imem_req is also the outstanding flag: it stays high exactly until the ack.
   assign ack_fire     = imem_req & imem_ack;
   assign out_hold     = imem_req & ~imem_ack;
   // Redirect wins: an ack in the redirect cycle is discarded and no entry is popped.
   assign push         = ack_fire & ~drop_flag & ~redirect;
   assign pop          = inst_valid & inst_ready & ~redirect;
   assign redirect_tgt = redirect_pc & ~32'h3;
   assign q_wr         = {imem_addr, imem_rdata};

`ifdef FETCH_MISALIGN_CHK_EN
   assign halted_next = redirect ? (redirect_pc[1:0] != 2'b00) : halted;

   // A misaligned redirect stops issue until an aligned redirect or reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         halted <= 1'b0;
      end else begin
         halted <= halted_next;
      end
   end
`else
   assign halted_next = 1'b0;
   assign halted      = 1'b0;
`endif

   assign misalign_err = halted;

   // Next PC, drop tracking, occupancy and the credit check for the next request.
   always_comb begin
      fetch_pc_next = fetch_pc;
      drop_next     = drop_flag;
      count_next    = q_count;
      if (redirect) begin
         fetch_pc_next = redirect_tgt;
         drop_next     = out_hold;
         count_next    = '0;
      end else begin
         if (push) begin
            fetch_pc_next = fetch_pc + PC_STEP;
         end
         if (ack_fire) begin
            drop_next = 1'b0;
         end
         case ({push, pop})
            2'b10:   count_next = q_count + CNT_W'(1);
            2'b01:   count_next = q_count - CNT_W'(1);
            default: count_next = q_count;
         endcase
      end
      // An unacked request is held; otherwise issue only if its word is sure to fit.
      req_next = out_hold | ((count_next < CNT_W'(DEPTH)) & ~halted_next);
   end

   // PC, request and drop registers; the address only moves when a new request is raised.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc  <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         drop_flag <= 1'b0;
      end else begin
         fetch_pc  <= fetch_pc_next;
         drop_flag <= drop_next;
         imem_req  <= req_next;
         if (req_next && !out_hold) begin
            imem_addr <= fetch_pc_next;
         end
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pop      (pop),
      .flush    (redirect),
      .wr_entry (q_wr),
      .head     (q_head),
      .count    (q_count),
      .full     (q_full),
      .empty    (q_empty)
   );

   assign inst_valid = ~q_empty;
   assign inst       = q_head.inst;
   assign inst_pc    = q_head.pc;

   // The credit check must make a push into a full queue impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && q_full));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        misalign_err;

   logic        zero_wait;
   logic        ack_force;
   logic        cur_zw;
   int          lat_cnt;
   int          n_checks;
   int          n_pass;

   typedef struct {
      logic        rst;
      logic        zw;
      logic        af;
      logic        rdy;
      logic        rd;
      logic [31:0] rpc;
      logic        ereq;
      logic [31:0] eaddr;
      logic        evld;
      logic [31:0] epc;
   } vec_t;

   vec_t vq[$];

   fetch_unit dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .inst         (inst),
      .inst_pc      (inst_pc),
      .misalign_err (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: zero-wait or ack in the third cycle of a request; ack_force injects a stray ack.
   assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
   assign imem_ack   = ack_force | (imem_req & (zero_wait | (lat_cnt == 2)));

   always @(posedge clk) begin
      if (reset || !imem_req || imem_ack) lat_cnt <= 0;
      else                                lat_cnt <= lat_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic add(input logic rst, input logic zw, input logic af, input logic rdy,
                      input logic rd, input logic [31:0] rpc, input logic ereq,
                      input logic [31:0] eaddr, input logic evld, input logic [31:0] epc);
      vec_t v;
      v.rst = rst; v.zw = zw; v.af = af; v.rdy = rdy; v.rd = rd; v.rpc = rpc;
      v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.epc = epc;
      vq.push_back(v);
   endtask

   // Reset cycle: everything back to the reset state.
   task automatic rst_v(input logic zw);
      cur_zw = zw;
      add(1'b1, zw, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   // Normal cycle with the memory mode chosen at the last reset.
   task automatic nv(input logic rdy, input logic rd, input logic [31:0] rpc, input logic ereq,
                     input logic [31:0] eaddr, input logic evld, input logic [31:0] epc);
      add(1'b0, cur_zw, 1'b0, rdy, rd, rpc, ereq, eaddr, evld, epc);
   endtask

   task automatic cyc(input logic rdy, input logic rd, input logic [31:0] rpc);
      reset = 1'b0; ack_force = 1'b0;
      inst_ready = rdy; redirect = rd; redirect_pc = rpc;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0; n_pass = 0;
      reset = 1'b1; zero_wait = 1'b1; ack_force = 1'b0; cur_zw = 1'b1;
      inst_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;

      // Streaming with zero-wait memory: addr 0,4,8,... and inst_pc trails by one cycle.
      rst_v(1'b1);
      for (int i = 1; i <= 5; i++)
         nv(1'b1, 1'b0, 0, 1'b1, 32'(4 * (i - 1)), (i >= 2), 32'(4 * (i - 2)));

      // Consumer stalled for 10 cycles: two words buffered, request withheld, head held at pc 0.
      rst_v(1'b1);
      nv(1'b0, 1'b0, 0, 1'b1, 32'h0, 1'b0, 32'h0);
      nv(1'b0, 1'b0, 0, 1'b1, 32'h4, 1'b1, 32'h0);
      for (int i = 3; i <= 10; i++)
         nv(1'b0, 1'b0, 0, 1'b0, 32'h4, 1'b1, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h8,  1'b1, 32'h4);
      nv(1'b1, 1'b0, 0, 1'b1, 32'hC,  1'b1, 32'h8);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h10, 1'b1, 32'hC);

      // 3-cycle memory; redirect to 0x100 in the second wait cycle of the pc-8 request.
      rst_v(1'b0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h0, 1'b0, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h0, 1'b0, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h0, 1'b0, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h4, 1'b1, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h4, 1'b0, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h4, 1'b0, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h8, 1'b1, 32'h4);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h8, 1'b0, 32'h0);
      nv(1'b1, 1'b1, 32'h100, 1'b1, 32'h8, 1'b0, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h100, 1'b0, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h100, 1'b0, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h100, 1'b0, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h104, 1'b1, 32'h100);

      // Redirect to 0x200 coinciding with the ack of pc 8 and the pop of pc 4.
      rst_v(1'b1);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h0, 1'b0, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h4, 1'b1, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h8, 1'b1, 32'h4);
      nv(1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h204, 1'b1, 32'h200);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h208, 1'b1, 32'h204);

      // PC wrap from the top of the address space.
      rst_v(1'b1);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h0, 1'b0, 32'h0);
      nv(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h4, 1'b1, 32'h0);

      // Reset mid-request, then a stray ack right after reset must be ignored.
      rst_v(1'b0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h0, 1'b0, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h0, 1'b0, 32'h0);
      rst_v(1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 32'h0, 1'b0, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h0, 1'b0, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h0, 1'b0, 32'h0);
      nv(1'b1, 1'b0, 0, 1'b1, 32'h4, 1'b1, 32'h0);

      @(negedge clk);
      for (int i = 0; i < vq.size(); i++) begin
         reset = vq[i].rst; zero_wait = vq[i].zw; ack_force = vq[i].af;
         inst_ready = vq[i].rdy; redirect = vq[i].rd; redirect_pc = vq[i].rpc;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d imem_req", i),   32'(imem_req),   32'(vq[i].ereq));
         chk($sformatf("v%0d imem_addr", i),  imem_addr,       vq[i].eaddr);
         chk($sformatf("v%0d inst_valid", i), 32'(inst_valid), 32'(vq[i].evld));
         if (vq[i].evld) begin
            chk($sformatf("v%0d inst_pc", i), inst_pc, vq[i].epc);
            chk($sformatf("v%0d inst", i),    inst,    vq[i].epc ^ 32'hA5A5_0000);
         end
         if (vq[i].rst) begin
            chk($sformatf("v%0d reset inst_pc", i),      inst_pc,           32'h0);
            chk($sformatf("v%0d reset inst", i),         inst,              32'h0);
            chk($sformatf("v%0d reset misalign_err", i), 32'(misalign_err), 32'h0);
         end
      end

      // Misaligned redirect to 0x102 while streaming from zero-wait memory.
      reset = 1'b1; zero_wait = 1'b1; ack_force = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cyc(1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_CHK_EN
      chk("mis set misalign_err", 32'(misalign_err), 32'h1);
      chk("mis set imem_req",     32'(imem_req),     32'h0);
      chk("mis set inst_valid",   32'(inst_valid),   32'h0);
      cyc(1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 32'h0);
      chk("mis halt imem_req",     32'(imem_req),     32'h0);
      chk("mis halt misalign_err", 32'(misalign_err), 32'h1);
      cyc(1'b1, 1'b1, 32'h104);
      chk("mis clr misalign_err", 32'(misalign_err), 32'h0);
      chk("mis clr imem_req",     32'(imem_req),     32'h1);
      chk("mis clr imem_addr",    imem_addr,         32'h104);
      cyc(1'b1, 1'b0, 32'h0);
      chk("mis resume inst_valid", 32'(inst_valid), 32'h1);
      chk("mis resume inst_pc",    inst_pc,         32'h104);
      chk("mis resume imem_addr",  imem_addr,       32'h108);
`else
      chk("trunc misalign_err", 32'(misalign_err), 32'h0);
      chk("trunc imem_req",     32'(imem_req),     32'h1);
      chk("trunc imem_addr",    imem_addr,         32'h100);
      cyc(1'b1, 1'b0, 32'h0);
      chk("trunc inst_valid",   32'(inst_valid),   32'h1);
      chk("trunc inst_pc",      inst_pc,           32'h100);
      chk("trunc inst",         inst,              32'h100 ^ 32'hA5A5_0000);
      chk("trunc misalign_err2", 32'(misalign_err), 32'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
